// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// ------------
// Timing generator for the 640x480 VGA display path. A clock divider
// produces a pixel-rate enable (pixel_tick); on each tick the horizontal
// counter advances, and the vertical counter advances when the horizontal
// counter wraps. The counters are exported as the x/y coordinate bus for
// the pixel-drawing blocks, together with active-low hsync/vsync and the
// video_on blanking flag.
//
// Optional feature macro: VGA_FRAME_COUNT_EN
//   When defined, an 8-bit frame_count output is added. It counts every
//   wrap of (x,y) to (0,0) and rolls over from 255 to 0.
//
// Ports
//   clk          in   board clock, rising edge
//   reset_n      in   asynchronous, active-low reset
//   x[9:0]       out  horizontal count, 0..H_TOTAL-1 (registered)
//   y[9:0]       out  vertical count, 0..V_TOTAL-1 (registered)
//   hsync        out  horizontal sync, active low (registered)
//   vsync        out  vertical sync, active low (registered)
//   video_on     out  high inside the visible area (registered)
//   pixel_tick   out  one-clk enable, counters advance on it
//   frame_start  out  high on the tick whose edge moves (x,y) onto (0,0)
//   frame_count  out  [7:0] frame counter (VGA_FRAME_COUNT_EN only)
//
// Reset leaves the counters on the last pixel of the frame (H_TOTAL-1,
// V_TOTAL-1), so the first pixel_tick after release wraps to (0,0) and
// pixel (0,0) of the first frame is displayed.

module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  // ---------------------------------------------------------------------
  // Derived timing constants
  // ---------------------------------------------------------------------
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // ---------------------------------------------------------------------
  // Pixel-rate divider
  // ---------------------------------------------------------------------
  generate
    if (CLK_DIV == 1) begin : g_no_div
      // Every board clock is a pixel clock; the enable is tied high,
      // which also holds while reset_n is low.
      assign pixel_tick = 1'b1;
    end else begin : g_div
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
          div_reg <= '0;
        end else begin
          div_reg <= div_reg + 1'b1;
        end
      end

      // Tick on the last divider phase so the first tick after reset
      // lands in clock cycle CLK_DIV.
      assign pixel_tick = (div_reg == DIV_LAST);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Horizontal / vertical counters
  // ---------------------------------------------------------------------
  logic [9:0] h_reg;
  logic [9:0] h_next;
  logic [9:0] v_reg;
  logic [9:0] v_next;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (h_reg == H_LAST);
  assign v_wrap = (v_reg == V_LAST);

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (pixel_tick) begin
      if (h_wrap) begin
        h_next = '0;
        // The vertical counter only moves on the line wrap; at the end of
        // the frame both counters clear on the same edge.
        v_next = v_wrap ? '0 : (v_reg + 10'd1);
      end else begin
        h_next = h_reg + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sync / blanking, decoded from the next counter values so that the
  // registered flags line up with the registered x/y with no lag.
  // ---------------------------------------------------------------------
  logic hsync_reg;
  logic hsync_next;
  logic vsync_reg;
  logic vsync_next;
  logic video_on_reg;
  logic video_on_next;

  always_comb begin
    hsync_next    = ~((h_next >= HS_START) && (h_next <= HS_END));
    vsync_next    = ~((v_next >= VS_START) && (v_next <= VS_END));
    video_on_next = (h_next < H_VIS) && (v_next < V_VIS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_reg        <= H_LAST;
      v_reg        <= V_LAST;
      hsync_reg    <= 1'b1;
      vsync_reg    <= 1'b1;
      video_on_reg <= 1'b0;
    end else begin
      h_reg        <= h_next;
      v_reg        <= v_next;
      hsync_reg    <= hsync_next;
      vsync_reg    <= vsync_next;
      video_on_reg <= video_on_next;
    end
  end

  assign x        = h_reg;
  assign y        = v_reg;
  assign hsync    = hsync_reg;
  assign vsync    = vsync_reg;
  assign video_on = video_on_reg;

  // frame_start marks the tick that loads (0,0): one pulse per frame,
  // coincident with the first pixel_tick after reset release.
  assign frame_start = pixel_tick & h_wrap & v_wrap;

  // ---------------------------------------------------------------------
  // Optional frame counter
  // ---------------------------------------------------------------------
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_reg <= 8'd0;
    end else if (frame_start) begin
      frame_count_reg <= frame_count_reg + 8'd1;
    end
  end

  assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen.
// Instance u_a uses the default 640x480 timing with CLK_DIV=2.
// Instance u_b uses CLK_DIV=1 and a shrunken geometry (15x12 totals) so
// whole frames fit in a short run. Expected pixel records are pushed into a
// per-instance queue by the stimulus; a monitor pops one record on every
// pixel_tick and compares.

module tb_vga_sync_gen;

  // u_b geometry: H 8+2+3+2 = 15, V 6+1+2+3 = 12, frame = 180 clks
  localparam int B_HD = 8;
  localparam int B_HF = 2;
  localparam int B_HS = 3;
  localparam int B_HB = 2;
  localparam int B_VD = 6;
  localparam int B_VF = 1;
  localparam int B_VS = 2;
  localparam int B_VB = 3;
`ifdef VGA_FRAME_COUNT_EN
  localparam int B_FRAMES = 257;
`else
  localparam int B_FRAMES = 3;
`endif

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
    bit fs;
    int fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n;
  logic       rst_b_n;
  logic [9:0] xa, ya, xb, yb;
  logic       hsa, vsa, vona, pta, fsa;
  logic       hsb, vsb, vonb, ptb, fsb;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fca, fcb;
`endif

  vga_sync_gen u_a (
    .clk         (clk),
    .reset_n     (rst_a_n),
    .x           (xa),
    .y           (ya),
    .hsync       (hsa),
    .vsync       (vsa),
    .video_on    (vona),
    .pixel_tick  (pta),
    .frame_start (fsa)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (fca)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV   (1),
    .H_DISPLAY (B_HD), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
    .V_DISPLAY (B_VD), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB)
  ) u_b (
    .clk         (clk),
    .reset_n     (rst_b_n),
    .x           (xb),
    .y           (yb),
    .hsync       (hsb),
    .vsync       (vsb),
    .video_on    (vonb),
    .pixel_tick  (ptb),
    .frame_start (fsb)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (fcb)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  bit   mon_a_en = 1'b0;
  bit   mon_b_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference decode of one pixel position from the timing parameters.
  function automatic exp_t model(input int h, input int v,
                                 input int hd, input int hf, input int hsw, input int hb,
                                 input int vd, input int vf, input int vsw, input int vb,
                                 input int fc);
    exp_t e;
    e.x   = h;
    e.y   = v;
    e.hs  = !((h >= hd + hf) && (h < hd + hf + hsw));
    e.vs  = !((v >= vd + vf) && (v < vd + vf + vsw));
    e.von = (h < hd) && (v < vd);
    e.fs  = (h == hd + hf + hsw + hb - 1) && (v == vd + vf + vsw + vb - 1);
    e.fc  = fc;
    return e;
  endfunction

  // ---------------------------------------------------------------------
  // Monitor A
  // ---------------------------------------------------------------------
  exp_t ea;
  int   a_idx = 0;
  int   a_hs_low = 0, a_hs_first = -1, a_hs_last = -1, a_von_fall = -1, a_line0 = 0;
  bit   a_prev_von = 1'b0;

  always @(negedge clk) begin
    if (rst_a_n && mon_a_en && pta) begin
      if (qa.size() == 0) begin
        check("a_unexpected_tick", 1, 0);
      end else begin
        bit ok;
        int fc_act;
        ea = qa.pop_front();
        ok = ({xa, ya, hsa, vsa, vona, fsa} ===
              {10'(ea.x), 10'(ea.y), ea.hs, ea.vs, ea.von, ea.fs});
`ifdef VGA_FRAME_COUNT_EN
        fc_act = int'(fca);
        ok = ok && (fca === 8'(ea.fc));
`else
        fc_act = ea.fc;
`endif
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL a_tick[%0d]: got x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b fc=%0d, required x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b fc=%0d",
                   a_idx, xa, ya, hsa, vsa, vona, fsa, fc_act,
                   ea.x, ea.y, ea.hs, ea.vs, ea.von, ea.fs, ea.fc);
        end
        a_idx++;
        if (ya == 10'd0) begin
          a_line0++;
          if (!hsa) begin
            a_hs_low++;
            if (a_hs_first < 0) a_hs_first = int'(xa);
            a_hs_last = int'(xa);
          end
          if (!vona && a_prev_von && a_von_fall < 0) a_von_fall = int'(xa);
        end
        a_prev_von = vona;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Monitor B
  // ---------------------------------------------------------------------
  exp_t eb;
  int   b_idx = 0, b_clks = 0, b_ticks = 0, b_vs_mask = 0, b_von_bad = 0;
  int   b_fs_cnt = 0, b_last_fs = -1;

  always @(negedge clk) begin
    if (rst_b_n && mon_b_en) begin
      b_clks++;
      if (ptb) begin
        b_ticks++;
        if (qb.size() == 0) begin
          check("b_unexpected_tick", 1, 0);
        end else begin
          bit ok;
          int fc_act;
          eb = qb.pop_front();
          ok = ({xb, yb, hsb, vsb, vonb, fsb} ===
                {10'(eb.x), 10'(eb.y), eb.hs, eb.vs, eb.von, eb.fs});
`ifdef VGA_FRAME_COUNT_EN
          fc_act = int'(fcb);
          ok = ok && (fcb === 8'(eb.fc));
`else
          fc_act = eb.fc;
`endif
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL b_tick[%0d]: got x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b fc=%0d, required x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b fc=%0d",
                     b_idx, xb, yb, hsb, vsb, vonb, fsb, fc_act,
                     eb.x, eb.y, eb.hs, eb.vs, eb.von, eb.fs, eb.fc);
          end
          b_idx++;
        end
        if (!vsb && yb < 10'd31) b_vs_mask |= (1 << yb);
        if (vonb && yb >= 10'(B_VD)) b_von_bad++;
        if (fsb) begin
          b_fs_cnt++;
          if (b_last_fs >= 0) check("b_frame_period_clks", b_clks - b_last_fs, 180);
          b_last_fs = b_clks;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus A: default timing, CLK_DIV=2
  // ---------------------------------------------------------------------
  task automatic check_reset_a(input string tag);
    check({tag, "_x"}, int'(xa), 799);
    check({tag, "_y"}, int'(ya), 524);
    check({tag, "_hsync"}, int'(hsa), 1);
    check({tag, "_vsync"}, int'(vsa), 1);
    check({tag, "_video_on"}, int'(vona), 0);
    check({tag, "_pixel_tick"}, int'(pta), 0);
    check({tag, "_frame_start"}, int'(fsa), 0);
`ifdef VGA_FRAME_COUNT_EN
    check({tag, "_frame_count"}, int'(fca), 0);
`endif
  endtask

  task automatic push_a(input int count);
    int h = 799;
    int v = 524;
    int fc = 0;
    for (int k = 0; k < count; k++) begin
      qa.push_back(model(h, v, 640, 16, 96, 48, 480, 10, 2, 33, fc));
      if (h == 799 && v == 524) fc = (fc + 1) % 256;
      h++;
      if (h == 800) begin
        h = 0;
        v = (v == 524) ? 0 : v + 1;
      end
    end
  endtask

  task automatic release_a(input string tag);
    int n;
    mon_a_en = 1'b1;
    @(posedge clk);
    #1 rst_a_n = 1'b1;
    n = 1;
    @(negedge clk);
    while (!pta && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_first_tick_cycle"}, n, 2);
    check({tag, "_first_tick_frame_start"}, int'(fsa), 1);
  endtask

  task automatic drain_a(input string tag);
    int n = 0;
    while (qa.size() != 0 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_drained"}, qa.size(), 0);
    qa.delete();
    mon_a_en = 1'b0;
  endtask

  task automatic run_a();
    rst_a_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_a("a_reset");

    // First frame start through pixel (300,1): 1 wrap record + 1101 pixels.
    push_a(1102);
    release_a("a_rel1");
    drain_a("a_seg1");

    // Line statistics over line 0, hand-derived from 640/16/96/48.
    check("a_line0_ticks", a_line0, 800);
    check("a_hsync_low_ticks", a_hs_low, 96);
    check("a_hsync_first_x", a_hs_first, 656);
    check("a_hsync_last_x", a_hs_last, 751);
    check("a_video_on_fall_x", a_von_fall, 640);

    // Asynchronous reset in the middle of the frame, between clock edges.
    check("a_mid_x", int'(xa), 300);
    check("a_mid_y", int'(ya), 1);
    rst_a_n = 1'b0;
    #1;
    check_reset_a("a_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_a("a_held");

    // After release the first tick again wraps to (0,0).
    push_a(3);
    release_a("a_rel2");
    drain_a("a_seg2");
  endtask

  // ---------------------------------------------------------------------
  // Stimulus B: CLK_DIV=1, small geometry, whole frames
  // ---------------------------------------------------------------------
  task automatic run_b();
    int h = 14;
    int v = 11;
    int fc = 0;
    int n = 0;
    rst_b_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b_reset_x", int'(xb), 14);
    check("b_reset_y", int'(yb), 11);
    check("b_reset_hsync", int'(hsb), 1);
    check("b_reset_vsync", int'(vsb), 1);
    check("b_reset_video_on", int'(vonb), 0);

    for (int k = 0; k < 1 + B_FRAMES * 180; k++) begin
      qb.push_back(model(h, v, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, fc));
      if (h == 14 && v == 11) fc = (fc + 1) % 256;
      h++;
      if (h == 15) begin
        h = 0;
        v = (v == 11) ? 0 : v + 1;
      end
    end

    mon_b_en = 1'b1;
    @(posedge clk);
    #1 rst_b_n = 1'b1;
    while (qb.size() != 0 && n < 60000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("b_drained", qb.size(), 0);
    qb.delete();
    mon_b_en = 1'b0;

    check("b_tick_every_clk", b_ticks, b_clks);
    check("b_vsync_low_lines_mask", b_vs_mask, (1 << 7) | (1 << 8));
    check("b_video_on_below_display", b_von_bad, 0);
    check("b_frame_start_pulses", b_fs_cnt, B_FRAMES + 1);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
